spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 192 +++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: issues READ (0x03) + 24-bit address in SPI mode 0 and
// streams back up to 256 bytes, with abort, chip-select hold-off and done pulse.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [8:0]  read_len,
    input  logic        abort,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        done,
    output logic        flash_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        CS_HOLD,
        DONE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_IDLE - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_reload;
    logic [8:0]  byte_cnt;
    logic [7:0]  hold_cnt;
    logic [30:0] tx_sr;
    logic [6:0]  rx_sr;
    logic        abort_pend;

    logic        active;
    logic        div_tc;
    logic        rise;
    logic        fall;
    logic        phase_end;
    logic        last_bit;
    logic        abort_req;
    logic        stop;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Bit-timing events; a bit ends on the edge that takes spi_clk high->low.
    assign active    = (state == CMD) || (state == ADDR) || (state == DATA);
    assign div_tc    = (div_cnt == DIV_LAST);
    assign rise      = active && div_tc && !spi_clk;
    assign fall      = active && div_tc && spi_clk;
    assign phase_end = fall && (bit_cnt == 5'd0);
    assign last_bit  = (state == DATA) && phase_end && (byte_cnt == 9'd0);
    assign abort_req = active && (abort || abort_pend);
    // An abort lands immediately while spi_clk is low, else at the end of the high phase.
    assign stop      = active && (last_bit || (abort_req && (!spi_clk || div_tc)));

    always_comb begin
        bit_cnt_reload = 5'd7;
        if (state == CMD) begin
            bit_cnt_reload = 5'd23;
        end
    end

    always_comb begin
        // NOTE: assign every combinational output a default first so no path infers a latch.
        state_next = state;
        unique case (state)
            IDLE: begin
                // Zero-length requests spend one cycle in CS_HOLD so done lands two cycles after start.
                if (start) begin
                    state_next = (read_len == 9'd0) ? CS_HOLD : CMD;
                end
            end
            CMD: begin
                if (stop) begin
                    state_next = CS_HOLD;
                end else if (phase_end) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (stop) begin
                    state_next = CS_HOLD;
                end else if (phase_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (stop) begin
                    state_next = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cs   <= 1'b1;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            byte_cnt   <= 9'd0;
            hold_cnt   <= 8'd0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            abort_pend <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE && start) begin
                flash_cs   <= (read_len == 9'd0);
                spi_clk    <= 1'b0;
                spi_mosi   <= (read_len == 9'd0) ? 1'b0 : CMD_READ[7];
                tx_sr      <= {CMD_READ[6:0], flash_addr};
                bit_cnt    <= 5'd7;
                byte_cnt   <= read_len;
                div_cnt    <= 8'd0;
                hold_cnt   <= 8'd0;
                abort_pend <= 1'b0;
            end else if (stop) begin
                flash_cs   <= 1'b1;
                spi_clk    <= 1'b0;
                spi_mosi   <= 1'b0;
                div_cnt    <= 8'd0;
                hold_cnt   <= HOLD_LAST;
                abort_pend <= 1'b0;
            end else if (active) begin
                if (abort) begin
                    abort_pend <= 1'b1;
                end
                if (div_tc) begin
                    div_cnt <= 8'd0;
                    spi_clk <= !spi_clk;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (rise && state == DATA) begin
                    rx_sr <= {rx_sr[5:0], spi_miso};
                    if (bit_cnt == 5'd0) begin
                        data_out   <= {rx_sr, spi_miso};
                        data_valid <= 1'b1;
                        byte_cnt   <= byte_cnt - 9'd1;
                    end
                end
                // Zeros shift in behind the address, so MOSI idles low through DATA.
                if (fall) begin
                    spi_mosi <= tx_sr[30];
                    tx_sr    <= {tx_sr[29:0], 1'b0};
                    bit_cnt  <= phase_end ? bit_cnt_reload : bit_cnt - 5'd1;
                end
            end else if (state == CS_HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: a behavioural SPI flash answers reads
// and a negedge monitor tallies chip-select, clock, data and done activity.
module tb_spi_flash_reader;

    localparam int CLK_DIV = 2;
    localparam int CS_IDLE = 4;
    localparam int BIT_CYC = 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] flash_addr = '0;
    logic [8:0]  read_len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        done;
    logic        flash_cs;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    int vectors = 0;
    int miscompares = 0;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .rst(rst), .start(start), .flash_addr(flash_addr),
        .read_len(read_len), .abort(abort), .busy(busy), .data_out(data_out),
        .data_valid(data_valid), .done(done), .flash_cs(flash_cs),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Flash model: captures the first 32 MOSI bits, serves mem[] MSB first afterwards.
    logic [7:0]  mem [8];
    logic [31:0] cmd_addr = '0;
    int          bitcnt = 0;
    int          data_mosi_viol = 0;
    int          mb;

    always @(posedge spi_clk or posedge flash_cs) begin
        if (flash_cs) begin
            bitcnt = 0;
        end else begin
            if (bitcnt < 32) cmd_addr = {cmd_addr[30:0], spi_mosi};
            else if (spi_mosi) data_mosi_viol++;
            bitcnt++;
        end
    end

    always @* begin
        mb = bitcnt - 32;
        spi_miso = 1'b0;
        if (mb >= 0 && mb < 64) spi_miso = mem[mb / 8][7 - (mb % 8)];
    end

    // Monitor sampled on the inactive clock edge.
    int         cyc = 0, cs_low = 0, cs_fall = 0, sclk_rise = 0, dv_n = 0, done_n = 0, idle_mosi_viol = 0;
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [7:0] dv_data [64];
    int         dv_time [64];

    always @(negedge clk) begin
        cyc++;
        if (flash_cs === 1'b0) cs_low++;
        if (prev_cs === 1'b1 && flash_cs === 1'b0) cs_fall++;
        if (prev_sclk === 1'b0 && spi_clk === 1'b1) sclk_rise++;
        prev_cs = flash_cs;
        prev_sclk = spi_clk;
        if (flash_cs === 1'b1 && spi_mosi !== 1'b0) idle_mosi_viol++;
        if (data_valid === 1'b1) begin
            if (dv_n < 64) begin
                dv_data[dv_n] = data_out;
                dv_time[dv_n] = cyc;
            end
            dv_n++;
        end
        if (done === 1'b1) done_n++;
    end

    task automatic launch(input logic [23:0] a, input logic [8:0] n);
        @(negedge clk);
        flash_addr = a;
        read_len = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        if (k >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bits(input string name, input int target);
        int k;
        for (k = 0; k < 2000 && bitcnt < target; k++) @(negedge clk);
        if (bitcnt < target) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_bit_wait: bitcnt %0d never reached %0d", name, bitcnt, target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        start = 1'b1;
        flash_addr = 24'h123456;
        read_len = 9'd3;
        repeat (3) @(negedge clk);
        start = 1'b0;
        vectors++; if (flash_cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b want 1", flash_cs); end
        vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b want 0", spi_clk); end
        vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (data_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: dv %b done %b want 0 0", data_valid, done); end
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_out); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int cl0, dv0, dn0;
        mem[0] = 8'hA5;
        cl0 = cs_low; dv0 = dv_n; dn0 = done_n;
        launch(24'h012345, 9'd1);
        flash_addr = 24'hFFFFFF;
        read_len = 9'd7;
        vectors++; if (flash_cs !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_first_cycle: cs %b busy %b want 0 1", flash_cs, busy); end
        vectors++; if (spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin miscompares++; $display("FAIL single_first_bit: sclk %b mosi %b want 0 0", spi_clk, spi_mosi); end
        wait_done("single", 400);
        vectors++; if (cmd_addr !== 32'h03012345) begin miscompares++; $display("FAIL single_cmd_addr: got %h want 03012345", cmd_addr); end
        vectors++; if (dv_n - dv0 !== 1) begin miscompares++; $display("FAIL single_dv_count: got %0d want 1", dv_n - dv0); end
        vectors++; if (dv_data[dv0] !== 8'hA5 || data_out !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h/%h want a5", dv_data[dv0], data_out); end
        vectors++; if (cs_low - cl0 !== (32 + 8) * BIT_CYC) begin miscompares++; $display("FAIL single_cs_low: got %0d want %0d", cs_low - cl0, (32 + 8) * BIT_CYC); end
        vectors++; if (done_n - dn0 !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d want 1", done_n - dn0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_multi();
        int cl0, dv0;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) mem[i] = exp_b[i];
        cl0 = cs_low; dv0 = dv_n;
        launch(24'hFFFFFE, 9'd4);
        wait_done("multi", 800);
        vectors++; if (cmd_addr !== 32'h03FFFFFE) begin miscompares++; $display("FAIL multi_cmd_addr: got %h want 03fffffe", cmd_addr); end
        vectors++; if (dv_n - dv0 !== 4) begin miscompares++; $display("FAIL multi_dv_count: got %0d want 4", dv_n - dv0); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (dv_data[dv0 + i] !== exp_b[i]) begin miscompares++; $display("FAIL multi_byte%0d: got %h want %h", i, dv_data[dv0 + i], exp_b[i]); end
        end
        // One byte is 8 bits of 2*CLK_DIV cycles each.
        for (int i = 1; i < 4; i++) begin
            vectors++; if (dv_time[dv0 + i] - dv_time[dv0 + i - 1] !== 8 * BIT_CYC) begin miscompares++; $display("FAIL multi_spacing%0d: got %0d want %0d", i, dv_time[dv0 + i] - dv_time[dv0 + i - 1], 8 * BIT_CYC); end
        end
        vectors++; if (cs_low - cl0 !== (32 + 32) * BIT_CYC) begin miscompares++; $display("FAIL multi_cs_low: got %0d want %0d", cs_low - cl0, (32 + 32) * BIT_CYC); end
    endtask

    task automatic test_zero_len();
        int cf0, sr0, dn0;
        cf0 = cs_fall; sr0 = sclk_rise; dn0 = done_n;
        launch(24'h000100, 9'd0);
        vectors++; if (busy !== 1'b1 || done !== 1'b0 || flash_cs !== 1'b1) begin miscompares++; $display("FAIL zero_cycle1: busy %b done %b cs %b want 1 0 1", busy, done, flash_cs); end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || flash_cs !== 1'b1) begin miscompares++; $display("FAIL zero_done_cycle2: done %b cs %b want 1 1", done, flash_cs); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL zero_cycle3: busy %b done %b want 0 0", busy, done); end
        repeat (2) @(negedge clk);
        vectors++; if (cs_fall - cf0 !== 0 || sclk_rise - sr0 !== 0) begin miscompares++; $display("FAIL zero_bus_quiet: cs falls %0d sclk rises %0d want 0 0", cs_fall - cf0, sclk_rise - sr0); end
        vectors++; if (done_n - dn0 !== 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_n - dn0); end
    endtask

    task automatic test_abort();
        int dv0, dn0, n;
        for (int i = 0; i < 8; i++) mem[i] = 8'hF0 + 8'(i);
        dv0 = dv_n; dn0 = done_n;
        launch(24'h000040, 9'd8);
        wait_bits("abort", 35);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (n = 1; n < 20 && flash_cs !== 1'b1; n++) @(negedge clk);
        vectors++; if (n > 2 * CLK_DIV + 1) begin miscompares++; $display("FAIL abort_latency: got %0d cycles want <= %0d", n, 2 * CLK_DIV + 1); end
        vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL abort_sclk: got %b want 0", spi_clk); end
        wait_done("abort", 100);
        vectors++; if (dv_n - dv0 !== 0) begin miscompares++; $display("FAIL abort_dv_count: got %0d want 0", dv_n - dv0); end
        vectors++; if (done_n - dn0 !== 1) begin miscompares++; $display("FAIL abort_done_count: got %0d want 1", done_n - dn0); end
    endtask

    task automatic test_rst_mid();
        int dv0, dn0;
        dn0 = done_n;
        launch(24'h777777, 9'd2);
        wait_bits("rst_mid", 16);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (flash_cs !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_state: cs %b sclk %b busy %b want 1 0 0", flash_cs, spi_clk, busy); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        vectors++; if (done_n - dn0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d want 0", done_n - dn0); end
        mem[0] = 8'h5A;
        mem[1] = 8'hC3;
        dv0 = dv_n;
        launch(24'hABCDEF, 9'd2);
        wait_done("rst_after", 600);
        vectors++; if (cmd_addr !== 32'h03ABCDEF) begin miscompares++; $display("FAIL rst_after_cmd_addr: got %h want 03abcdef", cmd_addr); end
        vectors++; if (dv_n - dv0 !== 2 || dv_data[dv0] !== 8'h5A || dv_data[dv0 + 1] !== 8'hC3) begin miscompares++; $display("FAIL rst_after_data: n %0d bytes %h %h want 2 5a c3", dv_n - dv0, dv_data[dv0], dv_data[dv0 + 1]); end
    endtask

    task automatic test_back_to_back();
        int cf0, dn0, k;
        cf0 = cs_fall; dn0 = done_n;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        mem[0] = 8'h3C;
        launch(24'h000010, 9'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        read_len = 9'd3;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 400 && done !== 1'b1; k++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        vectors++; if (cs_fall - cf0 !== 1) begin miscompares++; $display("FAIL b2b_transactions: got %0d want 1", cs_fall - cf0); end
        vectors++; if (done_n - dn0 !== 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 1", done_n - dn0); end
        vectors++; if (busy !== 1'b0 || flash_cs !== 1'b1) begin miscompares++; $display("FAIL b2b_idle: busy %b cs %b want 0 1", busy, flash_cs); end
        vectors++; if (idle_mosi_viol !== 0 || data_mosi_viol !== 0) begin miscompares++; $display("FAIL mosi_quiet: idle %0d data %0d want 0 0", idle_mosi_viol, data_mosi_viol); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        test_reset();
        test_single();
        test_multi();
        test_zero_len();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
